// File: rtl/snake_body_queue_if.sv
// Bundle of the snake_body_queue step signals.
// master: the side that issues steps and returns the collision flag.
// slave:  snake_body_queue itself.
interface snake_body_queue_if #(
   parameter int XW = 3,
   parameter int YW = 3,
   parameter int LW = 5
);
   logic                tick_in;
   logic [1:0]          dir;
   logic [XW-1:0]       food_x;
   logic [YW-1:0]       food_y;
   logic                self_hit_now;
   logic                tick;
   logic                eat;
   logic                will_pop;
   logic [XW+YW-1:0]    head_xy;
   logic [XW+YW-1:0]    tail_xy;
   logic [XW-1:0]       next_x;
   logic [YW-1:0]       next_y;
   logic [LW-1:0]       length;
   logic                food_eaten;
   logic                game_over;

   modport master (
      output tick_in, dir, food_x, food_y, self_hit_now,
      input  tick, eat, will_pop, head_xy, tail_xy, next_x, next_y,
             length, food_eaten, game_over
   );

   modport slave (
      input  tick_in, dir, food_x, food_y, self_hit_now,
      output tick, eat, will_pop, head_xy, tail_xy, next_x, next_y,
             length, food_eaten, game_over
   );
endinterface

// File: rtl/snake_body_queue.sv
// snake_body_queue: ring buffer of snake segments plus next-head logic.
// Optional feature: define SNAKE_WRAP_EN to make edge crossings wrap
// around the grid instead of ending the game.
//
// state | meaning
// RUN   | accepting game steps
// DEAD  | wall or self collision seen; waits for reset
module snake_body_queue #(
   parameter int XW      = 3,
   parameter int YW      = 3,
   parameter int GRID_W  = 8,
   parameter int GRID_H  = 6,
   parameter int MAX_LEN = 16,
   parameter int PW      = 4,
   parameter int LW      = 5,
   parameter int START_X = 2,
   parameter int START_Y = 2
) (
   input logic              clk,
   input logic              reset,
   snake_body_queue_if.slave bus
);
   localparam logic [0:0]         ST_RUN   = 1'b0;
   localparam logic [0:0]         ST_DEAD  = 1'b1;
   localparam int                 CW       = XW + YW;
   localparam logic [XW-1:0]      X_MAX    = XW'(GRID_W - 1);
   localparam logic [YW-1:0]      Y_MAX    = YW'(GRID_H - 1);
   localparam logic [CW-1:0]      START_XY = {XW'(START_X), YW'(START_Y)};
   localparam logic [PW-1:0]      PTR_LAST = PW'(MAX_LEN - 1);
   localparam logic [LW-1:0]      LEN_MAX  = LW'(MAX_LEN);
`ifdef SNAKE_WRAP_EN
   localparam logic               WALL_FATAL = 1'b0;
`else
   localparam logic               WALL_FATAL = 1'b1;
`endif

   logic [CW-1:0] seg_q [MAX_LEN];
   logic [CW-1:0] seg_d [MAX_LEN];
   logic [PW-1:0] head_ptr_q, head_ptr_d;
   logic [PW-1:0] tail_ptr_q, tail_ptr_d;
   logic [LW-1:0] length_q, length_d;
   logic [1:0]    cur_dir_q, cur_dir_d;
   logic [CW-1:0] head_xy_q, head_xy_d;
   logic          food_eaten_q, food_eaten_d;
   logic [0:0]    state_q, state_d;

   logic [1:0]    eff_dir;
   logic [XW-1:0] head_x, nx;
   logic [YW-1:0] head_y, ny;
   logic          edge_cross;
   logic          wall_hit;
   logic          food_match;
   logic          eat;
   logic          run_tick;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   // head copy kept in its own flop so head_xy is a clean register output
   assign head_x = head_xy_q[CW-1:YW];
   assign head_y = head_xy_q[YW-1:0];

   // a straight reversal would fold the snake onto itself, so it is ignored
   always_comb begin
      eff_dir = bus.dir;
      if ((bus.dir == (cur_dir_q ^ 2'b10)) && (length_q > LW'(1)))
         eff_dir = cur_dir_q;
   end

   // next head cell; the wrapped value is always produced, wall_hit decides if it is legal
   always_comb begin
      nx         = head_x;
      ny         = head_y;
      edge_cross = 1'b0;
      case (eff_dir)
         2'd0: begin
            if (head_y == '0) begin edge_cross = 1'b1; ny = Y_MAX; end
            else ny = head_y - YW'(1);
         end
         2'd1: begin
            if (head_x == X_MAX) begin edge_cross = 1'b1; nx = '0; end
            else nx = head_x + XW'(1);
         end
         2'd2: begin
            if (head_y == Y_MAX) begin edge_cross = 1'b1; ny = '0; end
            else ny = head_y + YW'(1);
         end
         default: begin
            if (head_x == '0) begin edge_cross = 1'b1; nx = X_MAX; end
            else nx = head_x - XW'(1);
         end
      endcase
      wall_hit = edge_cross & WALL_FATAL;
   end

   assign food_match = ({nx, ny} == {bus.food_x, bus.food_y});
   assign eat        = food_match && (length_q < LEN_MAX);
   assign run_tick   = bus.tick_in && (state_q == ST_RUN);

   assign bus.tick       = run_tick && !wall_hit;
   assign bus.eat        = eat;
   assign bus.will_pop   = !eat;
   assign bus.next_x     = nx;
   assign bus.next_y     = ny;
   assign bus.head_xy    = head_xy_q;
   assign bus.tail_xy    = seg_q[tail_ptr_q];
   assign bus.length     = length_q;
   assign bus.food_eaten = food_eaten_q;
   assign bus.game_over  = (state_q == ST_DEAD);

   // step update: advance head, grow or pop tail, or die without touching the body
   always_comb begin
      seg_d        = seg_q;
      head_ptr_d   = head_ptr_q;
      tail_ptr_d   = tail_ptr_q;
      length_d     = length_q;
      cur_dir_d    = cur_dir_q;
      head_xy_d    = head_xy_q;
      food_eaten_d = 1'b0;
      state_d      = state_q;
      if (run_tick) begin
         if (wall_hit || bus.self_hit_now) begin
            state_d = ST_DEAD;
         end else begin
            head_ptr_d        = ptr_inc(head_ptr_q);
            seg_d[head_ptr_d] = {nx, ny};
            head_xy_d         = {nx, ny};
            cur_dir_d         = eff_dir;
            food_eaten_d      = food_match;
            if (eat) length_d   = length_q + LW'(1);
            else     tail_ptr_d = ptr_inc(tail_ptr_q);
         end
      end
   end

   // state registers; reset restores a single-segment snake heading right
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= START_XY;
         head_ptr_q   <= '0;
         tail_ptr_q   <= '0;
         length_q     <= LW'(1);
         cur_dir_q    <= 2'd1;
         head_xy_q    <= START_XY;
         food_eaten_q <= 1'b0;
         state_q      <= ST_RUN;
      end else begin
         seg_q        <= seg_d;
         head_ptr_q   <= head_ptr_d;
         tail_ptr_q   <= tail_ptr_d;
         length_q     <= length_d;
         cur_dir_q    <= cur_dir_d;
         head_xy_q    <= head_xy_d;
         food_eaten_q <= food_eaten_d;
         state_q      <= state_d;
      end
   end
endmodule
